// File: rtl/reg_scoreboard_pkg.sv
// Shared types and widths for the register-hazard scoreboard and its
// writeback arbiter.
package scoreboard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int PEND_W    = 2;

  typedef enum logic {WB_EX = 1'b0, WB_MEM = 1'b1} wb_src_t;
  typedef logic [PEND_W-1:0] pend_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode, writeback and register-file port bundle of the scoreboard.
interface reg_scoreboard_if #(
  parameter int BITSIZE = 32
);
  import scoreboard_pkg::*;

  logic                 id_req_i;
  logic [REG_IDX_W-1:0] id_rs1_i;
  logic [REG_IDX_W-1:0] id_rs2_i;
  logic                 id_rs1_used_i;
  logic                 id_rs2_used_i;
  logic [REG_IDX_W-1:0] id_rd_i;
  logic                 id_rd_used_i;
  logic                 id_issue_i;
  logic                 id_access_o;
  logic                 ex_wb_req_i;
  logic                 mem_wb_req_i;
  logic [REG_IDX_W-1:0] ex_wb_rd_i;
  logic [REG_IDX_W-1:0] mem_wb_rd_i;
  logic [BITSIZE-1:0]   ex_wb_data_i;
  logic [BITSIZE-1:0]   mem_wb_data_i;
  logic                 ex_wb_gnt_o;
  logic                 mem_wb_gnt_o;
  logic                 rf_we_o;
  logic [REG_IDX_W-1:0] rf_waddr_o;
  logic [BITSIZE-1:0]   rf_wdata_o;
  logic                 flush_i;
  logic [31:0]          stall_cnt_o;

  modport slave (
    input  id_req_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_used_i, id_issue_i,
           ex_wb_req_i, mem_wb_req_i, ex_wb_rd_i, mem_wb_rd_i,
           ex_wb_data_i, mem_wb_data_i, flush_i,
    output id_access_o, ex_wb_gnt_o, mem_wb_gnt_o,
           rf_we_o, rf_waddr_o, rf_wdata_o, stall_cnt_o
  );

  modport master (
    output id_req_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_used_i, id_issue_i,
           ex_wb_req_i, mem_wb_req_i, ex_wb_rd_i, mem_wb_rd_i,
           ex_wb_data_i, mem_wb_data_i, flush_i,
    input  id_access_o, ex_wb_gnt_o, mem_wb_gnt_o,
           rf_we_o, rf_waddr_o, rf_wdata_o, stall_cnt_o
  );
endinterface

// File: rtl/reg_scoreboard_arb.sv
// Two-requester round-robin arbiter; grant is combinational, the priority
// pointer moves to the loser whenever a grant is given.
module rr_arbiter2
  import scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output wb_src_t    sel_o
);
  logic rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    sel_o = WB_EX;
    rr_d  = rr_q;
    if (!reset_i) begin
      if (req_i[0] && (!req_i[1] || !rr_q)) begin
        gnt_o = 2'b01;
        sel_o = WB_EX;
        rr_d  = 1'b1;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
        sel_o = WB_MEM;
        rr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard gating decode register access, plus
// the shared register-file write port fed by the EX/MEM writeback paths.
module reg_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int BITSIZE = 32,
  parameter int NREGS   = 32,
  parameter int PEND_W  = scoreboard_pkg::PEND_W
) (
  input  logic             clk,
  input  logic             reset_i,
  reg_scoreboard_if.slave  bus
);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic [31:0]       stall_q, stall_d;

  logic                 access;
  logic                 issue_fire;
  logic [1:0]           gnt;
  wb_src_t              sel;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [BITSIZE-1:0]   wb_data;
  logic                 retire;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_i (reset_i),
    .req_i   ({bus.mem_wb_req_i, bus.ex_wb_req_i}),
    .gnt_o   (gnt),
    .sel_o   (sel)
  );

  always_comb begin
    wb_rd   = (sel == WB_MEM) ? bus.mem_wb_rd_i   : bus.ex_wb_rd_i;
    wb_data = (sel == WB_MEM) ? bus.mem_wb_data_i : bus.ex_wb_data_i;
    // Writes to x0 are consumed by the grant but never reach the file.
    retire  = (|gnt) && (wb_rd != '0);
  end

  assign bus.ex_wb_gnt_o  = gnt[0];
  assign bus.mem_wb_gnt_o = gnt[1];
  assign bus.rf_we_o      = retire;
  assign bus.rf_waddr_o   = wb_rd;
  assign bus.rf_wdata_o   = wb_data;

  always_comb begin
    access = bus.id_req_i && !reset_i;
    if (bus.id_rs1_used_i && bus.id_rs1_i != '0 && pend_q[bus.id_rs1_i] != '0) access = 1'b0;
    if (bus.id_rs2_used_i && bus.id_rs2_i != '0 && pend_q[bus.id_rs2_i] != '0) access = 1'b0;
    if (bus.id_rd_used_i  && bus.id_rd_i  != '0 && pend_q[bus.id_rd_i] == PEND_MAX) access = 1'b0;
    issue_fire = bus.id_issue_i && access && bus.id_rd_used_i && (bus.id_rd_i != '0);
  end

  assign bus.id_access_o = access;
  assign bus.stall_cnt_o = stall_q;

  always_comb begin
    logic inc, dec;
    inc    = 1'b0;
    dec    = 1'b0;
    pend_d = pend_q;
    for (int r = 1; r < NREGS; r++) begin
      inc = issue_fire && (bus.id_rd_i == REG_IDX_W'(r));
      dec = retire && (wb_rd == REG_IDX_W'(r));
      if (bus.flush_i)                          pend_d[r] = '0;
      else if (inc && !dec)                     pend_d[r] = pend_q[r] + 1'b1;
      else if (dec && !inc && pend_q[r] != '0)  pend_d[r] = pend_q[r] - 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (bus.id_req_i && !access && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      stall_q <= '0;
    end else begin
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a pending-count model.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.BITSIZE(32)) bus ();
  reg_scoreboard #(.BITSIZE(32), .NREGS(32), .PEND_W(2)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int          m_pend [32];
  bit          m_rr;
  logic [31:0] m_stall;
  bit          m_ex_g_last, m_mem_g_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit exp_access();
    if (reset_i || !bus.id_req_i) return 1'b0;
    if (bus.id_rs1_used_i && bus.id_rs1_i != 0 && m_pend[bus.id_rs1_i] != 0) return 1'b0;
    if (bus.id_rs2_used_i && bus.id_rs2_i != 0 && m_pend[bus.id_rs2_i] != 0) return 1'b0;
    if (bus.id_rd_used_i && bus.id_rd_i != 0 && m_pend[bus.id_rd_i] == 3) return 1'b0;
    return 1'b1;
  endfunction

  // {mem, ex}
  function automatic bit [1:0] exp_gnt();
    if (reset_i) return 2'b00;
    if (bus.ex_wb_req_i && bus.mem_wb_req_i) return m_rr ? 2'b10 : 2'b01;
    if (bus.ex_wb_req_i) return 2'b01;
    if (bus.mem_wb_req_i) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    bit a;
    bit [1:0] g;
    int inc_r, dec_r;
    a = exp_access();
    g = exp_gnt();
    if (reset_i) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_rr = 1'b0; m_stall = '0; m_ex_g_last = 1'b0; m_mem_g_last = 1'b0;
    end else begin
      if (bus.id_req_i && !a && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      inc_r = -1;
      dec_r = -1;
      if (bus.id_issue_i && a && bus.id_rd_used_i && bus.id_rd_i != 0) inc_r = int'(bus.id_rd_i);
      if (g[0] && bus.ex_wb_rd_i != 0) dec_r = int'(bus.ex_wb_rd_i);
      if (g[1] && bus.mem_wb_rd_i != 0) dec_r = int'(bus.mem_wb_rd_i);
      if (bus.flush_i) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else if (inc_r != dec_r) begin
        if (inc_r >= 0) m_pend[inc_r] = m_pend[inc_r] + 1;
        if (dec_r >= 0 && m_pend[dec_r] > 0) m_pend[dec_r] = m_pend[dec_r] - 1;
      end
      if (g[0]) m_rr = 1'b1;
      else if (g[1]) m_rr = 1'b0;
      m_ex_g_last = g[0];
      m_mem_g_last = g[1];
    end
  end

  always @(negedge clk) begin
    bit [1:0] g;
    if (chk_en) begin
      g = exp_gnt();
      chk("access", 32'(bus.id_access_o), 32'(exp_access()));
      chk("ex_gnt", 32'(bus.ex_wb_gnt_o), 32'(g[0]));
      chk("mem_gnt", 32'(bus.mem_wb_gnt_o), 32'(g[1]));
      chk("stall_cnt", bus.stall_cnt_o, m_stall);
      if (g != 2'b00) begin
        chk("rf_we", 32'(bus.rf_we_o),
            32'(g[0] ? (bus.ex_wb_rd_i != 0) : (bus.mem_wb_rd_i != 0)));
        chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(g[0] ? bus.ex_wb_rd_i : bus.mem_wb_rd_i));
        chk("rf_wdata", bus.rf_wdata_o, g[0] ? bus.ex_wb_data_i : bus.mem_wb_data_i);
      end else begin
        chk("rf_we_idle", 32'(bus.rf_we_o), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_req_i = 0; bus.id_rs1_i = 0; bus.id_rs2_i = 0;
    bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0;
    bus.id_rd_i = 0; bus.id_rd_used_i = 0; bus.id_issue_i = 0;
    bus.ex_wb_req_i = 0; bus.mem_wb_req_i = 0;
    bus.ex_wb_rd_i = 0; bus.mem_wb_rd_i = 0;
    bus.ex_wb_data_i = 0; bus.mem_wb_data_i = 0;
    bus.flush_i = 0;
  endtask

  logic [31:0] alt_data [4];

  initial begin
    logic [31:0] ex_d, mem_d;
    alt_data[0] = 32'h1111_0000; alt_data[1] = 32'h2222_0000;
    alt_data[2] = 32'h1111_0001; alt_data[3] = 32'h2222_0001;
    idle_inputs();
    reset_i = 1'b1;
    step();
    chk_en = 1'b1;
    step();

    // Clean sources after reset
    reset_i = 1'b0;
    bus.id_req_i = 1; bus.id_rs1_i = 5; bus.id_rs1_used_i = 1;
    bus.id_rs2_i = 6; bus.id_rs2_used_i = 1;
    @(negedge clk);
    chk("lit_reset_access", 32'(bus.id_access_o), 32'd1);
    chk("lit_reset_stall", bus.stall_cnt_o, 32'd0);
    step();
    bus.id_rd_i = 5; bus.id_rd_used_i = 1; bus.id_issue_i = 1;
    @(negedge clk);
    chk("lit_issue_access", 32'(bus.id_access_o), 32'd1);
    step();
    bus.id_issue_i = 0; bus.id_rd_used_i = 0;
    @(negedge clk);
    chk("lit_raw_access", 32'(bus.id_access_o), 32'd0);
    chk("lit_raw_stall0", bus.stall_cnt_o, 32'd0);
    step();
    @(negedge clk);
    chk("lit_raw_stall1", bus.stall_cnt_o, 32'd1);
    step();
    bus.ex_wb_req_i = 1; bus.ex_wb_rd_i = 5; bus.ex_wb_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lit_wb_gnt", 32'(bus.ex_wb_gnt_o), 32'd1);
    chk("lit_wb_we", 32'(bus.rf_we_o), 32'd1);
    chk("lit_wb_addr", 32'(bus.rf_waddr_o), 32'd5);
    chk("lit_wb_data", bus.rf_wdata_o, 32'hDEAD_BEEF);
    chk("lit_wb_access", 32'(bus.id_access_o), 32'd0);
    chk("lit_wb_stall2", bus.stall_cnt_o, 32'd2);
    step();
    bus.ex_wb_req_i = 0;
    @(negedge clk);
    chk("lit_after_wb_access", 32'(bus.id_access_o), 32'd1);
    chk("lit_after_wb_stall3", bus.stall_cnt_o, 32'd3);

    // Round-robin alternation from a fresh pointer
    step();
    reset_i = 1; idle_inputs();
    step();
    reset_i = 0;
    ex_d = 32'h1111_0000; mem_d = 32'h2222_0000;
    bus.ex_wb_req_i = 1; bus.ex_wb_rd_i = 10; bus.ex_wb_data_i = ex_d;
    bus.mem_wb_req_i = 1; bus.mem_wb_rd_i = 11; bus.mem_wb_data_i = mem_d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_rr_ex", 32'(bus.ex_wb_gnt_o), 32'((k % 2) == 0));
      chk("lit_rr_mem", 32'(bus.mem_wb_gnt_o), 32'((k % 2) == 1));
      chk("lit_rr_data", bus.rf_wdata_o, alt_data[k]);
      step();
      if ((k % 2) == 0) begin ex_d = ex_d + 1; bus.ex_wb_data_i = ex_d; end
      else begin mem_d = mem_d + 1; bus.mem_wb_data_i = mem_d; end
    end
    bus.ex_wb_req_i = 0; bus.mem_wb_req_i = 0;

    // Pending saturation on x7
    bus.id_req_i = 1; bus.id_rd_i = 7; bus.id_rd_used_i = 1; bus.id_issue_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_x7_issue", 32'(bus.id_access_o), 32'd1);
      step();
    end
    @(negedge clk);
    chk("lit_x7_full", 32'(bus.id_access_o), 32'd0);
    step();
    bus.ex_wb_req_i = 1; bus.ex_wb_rd_i = 7; bus.ex_wb_data_i = 32'h7;
    @(negedge clk);
    chk("lit_x7_full_wb", 32'(bus.id_access_o), 32'd0);
    chk("lit_x7_wb_gnt", 32'(bus.ex_wb_gnt_o), 32'd1);
    step();
    bus.ex_wb_data_i = 32'h77;
    @(negedge clk);
    chk("lit_x7_incdec_access", 32'(bus.id_access_o), 32'd1);
    chk("lit_x7_incdec_gnt", 32'(bus.ex_wb_gnt_o), 32'd1);
    step();
    bus.ex_wb_req_i = 0;
    @(negedge clk);
    chk("lit_x7_pend2", 32'(bus.id_access_o), 32'd1);
    step();
    @(negedge clk);
    chk("lit_x7_pend3", 32'(bus.id_access_o), 32'd0);
    step();

    // x0 write and x0 sources
    bus.id_issue_i = 0; bus.id_rd_used_i = 0;
    bus.id_rs1_i = 0; bus.id_rs1_used_i = 1; bus.id_rs2_i = 0; bus.id_rs2_used_i = 1;
    bus.mem_wb_req_i = 1; bus.mem_wb_rd_i = 0; bus.mem_wb_data_i = 32'h5555;
    @(negedge clk);
    chk("lit_x0_gnt", 32'(bus.mem_wb_gnt_o), 32'd1);
    chk("lit_x0_we", 32'(bus.rf_we_o), 32'd0);
    chk("lit_x0_access", 32'(bus.id_access_o), 32'd1);
    step();

    // Flush then a late write
    bus.mem_wb_req_i = 0; bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0;
    bus.id_rd_i = 3; bus.id_rd_used_i = 1; bus.id_issue_i = 1;
    step();
    bus.id_rd_i = 4;
    step();
    bus.id_issue_i = 0; bus.id_rd_used_i = 0; bus.flush_i = 1;
    bus.id_rs1_i = 3; bus.id_rs1_used_i = 1;
    @(negedge clk);
    chk("lit_preflush_access", 32'(bus.id_access_o), 32'd0);
    step();
    bus.flush_i = 0; bus.id_rs2_i = 4; bus.id_rs2_used_i = 1;
    bus.ex_wb_req_i = 1; bus.ex_wb_rd_i = 3; bus.ex_wb_data_i = 32'h33;
    @(negedge clk);
    chk("lit_flush_access", 32'(bus.id_access_o), 32'd1);
    step();
    bus.ex_wb_req_i = 0;
    @(negedge clk);
    chk("lit_late_wb_access", 32'(bus.id_access_o), 32'd1);
    step();

    // Reset mid-stall
    bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0;
    bus.id_rd_i = 9; bus.id_rd_used_i = 1; bus.id_issue_i = 1;
    step();
    bus.id_issue_i = 0; bus.id_rd_used_i = 0; bus.id_rs1_i = 9; bus.id_rs1_used_i = 1;
    @(negedge clk);
    chk("lit_stall9_a", 32'(bus.id_access_o), 32'd0);
    step();
    reset_i = 1;
    @(negedge clk);
    chk("lit_in_reset_access", 32'(bus.id_access_o), 32'd0);
    step();
    reset_i = 0;
    @(negedge clk);
    chk("lit_post_reset_stall", bus.stall_cnt_o, 32'd0);
    chk("lit_post_reset_access", 32'(bus.id_access_o), 32'd1);
    step();

    // Randomized traffic honouring the requester hold rule
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      reset_i = ($urandom_range(0, 199) == 0);
      bus.flush_i = ($urandom_range(0, 49) == 0);
      bus.id_req_i = ($urandom_range(0, 3) != 0);
      bus.id_rs1_i = 5'($urandom_range(0, 7));
      bus.id_rs2_i = 5'($urandom_range(0, 7));
      bus.id_rd_i  = 5'($urandom_range(0, 7));
      bus.id_rs1_used_i = 1'($urandom_range(0, 1));
      bus.id_rs2_used_i = 1'($urandom_range(0, 1));
      bus.id_rd_used_i  = 1'($urandom_range(0, 1));
      bus.id_issue_i    = ($urandom_range(0, 2) != 0);
      if (!bus.ex_wb_req_i || m_ex_g_last) begin
        bus.ex_wb_req_i  = 1'($urandom_range(0, 1));
        bus.ex_wb_rd_i   = 5'($urandom_range(0, 7));
        bus.ex_wb_data_i = $urandom;
      end
      if (!bus.mem_wb_req_i || m_mem_g_last) begin
        bus.mem_wb_req_i  = 1'($urandom_range(0, 1));
        bus.mem_wb_rd_i   = 5'($urandom_range(0, 7));
        bus.mem_wb_data_i = $urandom;
      end
      step();
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard and register-file write-port arbiter between the decode stage, the execute/memory writeback paths and the register file. It keeps a pending-write count per architectural register and raises the decode stage's register-access grant only when every source it reads is clean. It also shares the single register-file write port between the EX and MEM writeback requesters with round-robin arbitration.

## Interface
- BITSIZE, 32, data width of register-file write data
- NREGS, 32, number of architectural registers; index width is clog2(NREGS) = 5
- PEND_W, 2, width of each per-register pending counter; saturates at 2^PEND_W-1
- clk  in  1  clock; all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- id_req_i  in  1  decode stage is in its decode state and requests register access
- id_rs1_i, id_rs2_i  in  5  source register indices
- id_rs1_used_i, id_rs2_used_i  in  1  source is read by this instruction
- id_rd_i  in  5  destination register index
- id_rd_used_i  in  1  instruction writes id_rd_i
- id_issue_i  in  1  decode hands the instruction to EX this cycle
- id_access_o  out  1  register access granted; drives the decode stage's access input
- ex_wb_req_i, mem_wb_req_i  in  1  writeback request
- ex_wb_rd_i, mem_wb_rd_i  in  5  writeback destination
- ex_wb_data_i, mem_wb_data_i  in  BITSIZE  writeback data
- ex_wb_gnt_o, mem_wb_gnt_o  out  1  writeback accepted this cycle
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  BITSIZE  register-file write data
- flush_i  in  1  discard all pending-write tracking
- stall_cnt_o  out  32  saturating count of cycles with id_req_i high and id_access_o low

## Operation
- State: pend[1..NREGS-1] counters (PEND_W bits), rr_q (1 bit, 0 = EX has priority), stall counter. x0 is never tracked and always reads clean.
- Access: id_access_o = id_req_i & !reset_i & (!rs1_used | rs1==0 | pend[rs1]==0) & (!rs2_used | rs2==0 | pend[rs2]==0) & (!rd_used | rd==0 | pend[rd] != max).
- Issue: an issue is counted only when id_issue_i & id_access_o & id_rd_used_i & id_rd_i != 0. It increments pend[rd]. id_issue_i without id_access_o is ignored.
- Arbiter: grant is combinational.
  - Both requesting: grant the side selected by rr_q, then rr_q points to the other side.
  - One requesting: grant it, and rr_q points to the other side.
  - None requesting: rr_q holds.
- Write port: rf_waddr_o and rf_wdata_o are muxed from the granted requester. rf_we_o = grant & waddr != 0. A write to x0 is granted (consumed) but not performed.
- Requester hold rule: a requester holds req, rd and data stable until it sees its grant.
- Retire: a granted write with rd != 0 decrements pend[rd]. Decrement saturates at 0.
- Same register incremented and decremented in the same cycle: net unchanged.
- Flush: all pend cleared next cycle; flush overrides any inc/dec in that cycle. Grants and writes in that cycle still happen. rr_q is unaffected.
- Stall counter: increments when id_req_i & !id_access_o; saturates at 0xFFFF_FFFF.

## Timing
- Reset (reset_i high at posedge): pend all 0, rr_q = 0, stall_cnt_o = 0.
- While reset_i is high, id_access_o, both grants and rf_we_o are forced 0. Reset mid-operation drops all tracking.
- id_access_o and grants have zero latency and are combinational from inputs and current state.
- A counter update is visible on the cycle after the issuing or retiring edge.
- The register file writes at the grant edge. A dependent read is granted on the next cycle (pend == 0), with no bypass path, so it reads the new value.
- Back-to-back issues to the same rd accumulate up to max (3). A further writer of that rd stalls until one retires.

## Structure
- Package scoreboard_pkg holds:
  - REG_IDX_W = 5
  - PEND_W default
  - typedef wb_src_t enum {WB_EX, WB_MEM}
  - typedef pend_t logic [PEND_W-1:0]
- Sub-module rr_arbiter2: 2-requester round-robin with registered pointer; outputs a one-hot grant plus a wb_src_t select.
- The scoreboard array, access logic and stall counter live in reg_scoreboard.

## Test plan
- Reset, then id_req_i = 1, rs1 = 5 and rs2 = 6 used -> id_access_o = 1, stall_cnt_o = 0.
- Issue rd = 5; next cycle request rs1 = 5 -> access 0 and stall count increments each cycle. EX writes x5 = 0xDEADBEEF (grant, rf_we_o = 1) -> access 1 on the following cycle.
- EX and MEM request every cycle for 4 cycles -> grants alternate EX, MEM, EX, MEM. Each requester's data appears on rf_wdata_o in its granted cycle.
- Three issues to rd = 7, fourth instruction with rd = 7 -> access 0 until one write to x7 retires. Issue and retire of x7 in the same cycle -> pend unchanged.
- MEM writes rd = 0 -> mem_wb_gnt_o = 1, rf_we_o = 0. Source x0 is always clean.
- Pending on x3 and x4, assert flush_i -> both clean next cycle. Late write to x3 -> counter stays 0. reset_i mid-stall -> access 0 and stall_cnt_o = 0 after the edge.
